serial_subtractor: RTL and testbench

//  Bit-serial, multi-cycle W-bit unsigned subtractor: diff = a - b - bin, with a borrow-out.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   SS_STATE_W  - width of the FSM state register
//   SS_IDLE     - waiting for start; ready=1
//   SS_BUSY     - shifting one bit per clock through the full-subtractor cell
//   SS_DONE     - one-cycle completion state; done=1
// Encoding 2'd3 is unused and recovers to SS_IDLE.
package serial_sub_pkg;

    localparam int SS_STATE_W = 2;

    localparam logic [SS_STATE_W-1:0] SS_IDLE = 2'd0;
    localparam logic [SS_STATE_W-1:0] SS_BUSY = 2'd1;
    localparam logic [SS_STATE_W-1:0] SS_DONE = 2'd2;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: x - y - bin.
//
// Ports:
//   x    in  1  minuend bit
//   y    in  1  subtrahend bit
//   bin  in  1  borrow from the less significant bit
//   d    out 1  difference bit
//   bout out 1  borrow into the more significant bit
// Purely combinational.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // A borrow is produced when y exceeds x outright, or when x==y and a
    // borrow arrives from below.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit unsigned subtractor: diff = (a - b - bin) mod 2^W, with
// borrow-out. One full-subtractor cell and a borrow flop are reused over W
// clocks, LSB first.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  synchronous, active-high reset
//   start  in  1  request; only sampled while ready=1
//   a      in  W  minuend, captured on the accepted start edge
//   b      in  W  subtrahend, captured on the accepted start edge
//   bin    in  1  borrow-in, captured on the accepted start edge
//   ready  out 1  FSM in IDLE
//   busy   out 1  FSM in BUSY
//   done   out 1  one-cycle pulse; diff/bout valid from this cycle on
//   diff   out W  result
//   bout   out 1  1 iff a < b + bin
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. The result appears W clocks later together with a single done
// pulse. start is ignored (not queued) while busy or done is high. ready,
// busy and done decode straight from the state register, so there is no
// combinational path from start to any output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SS_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [W-1:0]          a_sh_q,  a_sh_d;
    logic [W-1:0]          b_sh_q,  b_sh_d;
    logic [W-1:0]          r_sh_q,  r_sh_d;
    logic                  brw_q,   brw_d;
    logic [W-1:0]          diff_q,  diff_d;
    logic                  bout_q,  bout_d;

    // ------------------------------------------------------------------
    // Shared full-subtractor cell, fed from the LSBs of the shift regs
    // ------------------------------------------------------------------
    logic fs_d;
    logic fs_bo;

    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bo)
    );

    // Result bits enter at the MSB and move down, so after W shifts the
    // first (LSB) result bit sits at position 0.
    logic [W-1:0] r_next;
    assign r_next = {fs_d, r_sh_q[W-1:1]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            SS_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = SS_BUSY;
                end
            end

            SS_BUSY: begin
                r_sh_d = r_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                brw_d  = fs_bo;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Outputs update only here, so they stay stable for
                    // the whole run and hold until the next completion.
                    diff_d  = r_next;
                    bout_d  = fs_bo;
                    // Explicit clear keeps the counter correct when W is
                    // not a power of two.
                    cnt_d   = '0;
                    state_d = SS_DONE;
                end
            end

            SS_DONE: begin
                state_d = SS_IDLE;
            end

            default: begin
                state_d = SS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SS_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready = (state_q == SS_IDLE);
    assign busy  = (state_q == SS_BUSY);
    assign done  = (state_q == SS_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: inputs change and outputs are sampled on the falling edge.
    // Starts one operation and follows it to completion, checking busy
    // length, output stability during the run, the done pulse and result.
    // Returns in the IDLE cycle right after done, so a following call is a
    // back-to-back start.
    // ------------------------------------------------------------------
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic [W-1:0] exp_d, input logic exp_b);
        logic [W-1:0] old_d;
        logic         old_b;
        int           n_busy;
        old_d = diff;
        old_b = bout;
        check({tag, "_ready"}, 32'(ready), 32'(1));
        a = ta; b = tb_v; bin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v; bin = ~tc;   // later operand changes must not matter
        n_busy = 0;
        while (busy && n_busy < 20) begin
            n_busy++;
            check({tag, "_hold_diff"}, 32'(diff), 32'(old_d));
            check({tag, "_hold_bout"}, 32'(bout), 32'(old_b));
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(W));
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_diff"}, 32'(diff), 32'(exp_d));
        check({tag, "_bout"}, 32'(bout), 32'(exp_b));
        @(negedge clk);
        check({tag, "_done_clr"}, 32'(done), 32'(0));
        check({tag, "_ready_after"}, 32'(ready), 32'(1));
    endtask

    // ------------------------------------------------------------------
    // Scoreboard for the exhaustive sweep
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    logic         expb_q[$];

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_diff",  32'(diff),  32'(0));
        check("rst_bout",  32'(bout),  32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1-3: directed vectors
        run_op("t1_9m4",   4'd9, 4'd4, 1'b0, 4'h5, 1'b0);
        run_op("t2_3m5",   4'd3, 4'd5, 1'b0, 4'hE, 1'b1);
        run_op("t2_0m0b1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
        run_op("t3_7m7",   4'd7, 4'd7, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("t3_idle_diff", 32'(diff), 32'(0));
            check("t3_idle_bout", 32'(bout), 32'(0));
            @(negedge clk);
        end

        // 4: start while busy is ignored
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_ready_run", 32'(ready), 32'(0));
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        check("t4_ready_run2", 32'(ready), 32'(0));
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                n_done++;
                check("t4_diff", 32'(diff), 32'(5));
                check("t4_bout", 32'(bout), 32'(0));
            end
            @(negedge clk);
        end
        check("t4_done_count", 32'(n_done), 32'(1));
        check("t4_idle_busy", 32'(busy), 32'(0));

        // 5: reset mid-run aborts; diff currently 5 from test 4
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy1", 32'(busy), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", 32'(ready), 32'(1));
        check("t5_busy",  32'(busy),  32'(0));
        check("t5_diff",  32'(diff),  32'(0));
        check("t5_bout",  32'(bout),  32'(0));
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("t5_no_done", 32'(n_done), 32'(0));

        // 6: back-to-back, then exhaustive sweep (every op starts in the
        // cycle right after the previous done)
        run_op("t6_b2b_a", 4'd12, 4'd3, 1'b1, 4'h8, 1'b0);
        run_op("t6_b2b_b", 4'd15, 4'd0, 1'b0, 4'hF, 1'b0);
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    exp_q.push_back(W'((ia - ib - ic) & 15));
                    expb_q.push_back(ia < (ib + ic));
                    run_op("t6_sweep", W'(ia), W'(ib), ic[0], exp_q.pop_front(), expb_q.pop_front());
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_subtractor
